// File: rtl/maze_pkg.sv
// Shared types for the wall-follower maze walker.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package maze_pkg;

  // Facing directions; +1 turns clockwise (E -> S -> W -> N).
  typedef enum logic [1:0] {
    DIR_E = 2'd0,
    DIR_S = 2'd1,
    DIR_W = 2'd2,
    DIR_N = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_START,
    ST_CHK_START,
    ST_MARK,
    ST_PROBE_SIDE,
    ST_CHK_SIDE,
    ST_PROBE_FWD,
    ST_CHK_FWD,
    ST_ROTATE,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [1:0] FAIL_NONE       = 2'd0;
  localparam logic [1:0] FAIL_START_WALL = 2'd1;
  localparam logic [1:0] FAIL_ENCLOSED   = 2'd2;
  localparam logic [1:0] FAIL_TIMEOUT    = 2'd3;

  // Turn towards the followed wall: clockwise for right hand, anticlockwise for left.
  function automatic dir_t hand_turn(input dir_t d, input logic left);
    logic [1:0] t;
    t = left ? (d - 2'd1) : (d + 2'd1);
    return dir_t'(t);
  endfunction

  // Turn away from the followed wall.
  function automatic dir_t away_turn(input dir_t d, input logic left);
    return hand_turn(d, !left);
  endfunction

endpackage

// File: rtl/maze_if.sv
// Start/status handshake and maze memory port of the maze walker.
// Latency: n/a (wiring only).
// Backpressure: none; start is a one-cycle request, memory answers one cycle after maze_oe.
// Ports: master = walker side (drives memory address/strobes and status),
//        slave  = environment side (drives start request and memory read data).
interface maze_if #(
  parameter int ADDR_W = 6,
  parameter int STEP_W = 16
);
  import maze_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] starting_row;
  logic [ADDR_W-1:0] starting_col;
  dir_t              start_dir;
  logic              maze_in;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic              maze_oe;
  logic              maze_we;
  logic              busy;
  logic              done;
  logic              fail;
  logic [1:0]        fail_code;
  logic [STEP_W-1:0] step_count;

  modport master (
    input  start, starting_row, starting_col, start_dir, maze_in,
    output row, col, maze_oe, maze_we, busy, done, fail, fail_code, step_count
  );

  modport slave (
    output start, starting_row, starting_col, start_dir, maze_in,
    input  row, col, maze_oe, maze_we, busy, done, fail, fail_code, step_count
  );
endinterface

// File: rtl/maze_neighbour.sv
// Neighbour cell of the current position in the forward or hand-turn direction.
// Latency: combinational.
// Backpressure: n/a.
// Ports: i_row/i_col current cell, i_dir facing, i_side selects hand-turn neighbour
//        (else forward); o_row/o_col neighbour cell, o_oob set when it lies off the grid.
module maze_neighbour
  import maze_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int ROWS   = 64,
  parameter int COLS   = 64,
  parameter int HAND   = 0
) (
  input  logic [ADDR_W-1:0] i_row,
  input  logic [ADDR_W-1:0] i_col,
  input  dir_t              i_dir,
  input  logic              i_side,
  output logic [ADDR_W-1:0] o_row,
  output logic [ADDR_W-1:0] o_col,
  output logic              o_oob
);

  localparam logic signed [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic        [ADDR_W:0] ROWS_U = ROWS[ADDR_W:0];
  localparam logic        [ADDR_W:0] COLS_U = COLS[ADDR_W:0];

  dir_t                    w_dir;
  logic signed [ADDR_W:0]  w_row;
  logic signed [ADDR_W:0]  w_col;

  always_comb begin
    w_dir = i_side ? hand_turn(i_dir, HAND != 0) : i_dir;
    w_row = $signed({1'b0, i_row});
    w_col = $signed({1'b0, i_col});
    case (w_dir)
      DIR_E:   w_col = w_col + ONE;
      DIR_S:   w_row = w_row + ONE;
      DIR_W:   w_col = w_col - ONE;
      DIR_N:   w_row = w_row - ONE;
      default: ;
    endcase
  end

  // The extra top bit is set both for 0-1 and for (2**ADDR_W-1)+1, so neither wraps
  // into a legal coordinate; otherwise the low bits are the true coordinate.
  assign o_oob = w_row[ADDR_W] || w_col[ADDR_W] ||
                 ({1'b0, w_row[ADDR_W-1:0]} >= ROWS_U) ||
                 ({1'b0, w_col[ADDR_W-1:0]} >= COLS_U);
  assign o_row = w_row[ADDR_W-1:0];
  assign o_col = w_col[ADDR_W-1:0];

endmodule

// File: rtl/maze_walker.sv
// Wall-follower maze solver: walks from a start cell to any other border cell, marking visits.
// Latency: 3 cycles per step when the hand-side cell is free, more when probing/rotating.
// Backpressure: none; start is ignored while busy, memory data is expected one cycle after maze_oe.
// Ports: clk, rst_n (async, active-low); bus = maze_if.master (start/status + maze memory port).
module maze_walker
  import maze_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter int                ROWS      = 64,
  parameter int                COLS      = 64,
  parameter int                HAND      = 0,
  parameter int                STEP_W    = 16,
  parameter logic [STEP_W-1:0] MAX_STEPS = '1
) (
  input  logic  clk,
  input  logic  rst_n,
  maze_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(COLS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic              LEFT     = (HAND != 0);

  state_t            r_state,     w_state_nxt;
  logic [ADDR_W-1:0] r_cur_row,   w_cur_row_nxt;
  logic [ADDR_W-1:0] r_cur_col,   w_cur_col_nxt;
  logic [ADDR_W-1:0] r_st_row,    w_st_row_nxt;
  logic [ADDR_W-1:0] r_st_col,    w_st_col_nxt;
  dir_t              r_dir,       w_dir_nxt;
  logic [1:0]        r_rot,       w_rot_nxt;
  logic [STEP_W-1:0] r_steps,     w_steps_nxt;
  logic [ADDR_W-1:0] r_row,       w_row_nxt;
  logic [ADDR_W-1:0] r_col,       w_col_nxt;
  logic              r_oe,        w_oe_nxt;
  logic              r_we,        w_we_nxt;
  logic              r_busy,      w_busy_nxt;
  logic              r_done,      w_done_nxt;
  logic              r_fail,      w_fail_nxt;
  logic [1:0]        r_code,      w_code_nxt;

  dir_t              w_nb_dir;
  logic              w_nb_side;
  logic [ADDR_W-1:0] w_nb_row;
  logic [ADDR_W-1:0] w_nb_col;
  logic              w_nb_oob;
  logic              w_is_exit;
  logic              w_go_mark;
  logic              w_go_probe;
  state_t            w_probe_st;
  logic              w_go_fail;
  logic [1:0]        w_fail_code;

  // Outputs are registered, so the probe address is computed one state early:
  // MARK looks at the hand-side cell, ROTATE at the forward cell after turning away.
  always_comb begin
    w_nb_dir  = r_dir;
    w_nb_side = 1'b0;
    if (r_state == ST_MARK)   w_nb_side = 1'b1;
    if (r_state == ST_ROTATE) w_nb_dir  = away_turn(r_dir, LEFT);
  end

  maze_neighbour #(
    .ADDR_W (ADDR_W),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .HAND   (HAND)
  ) u_nb (
    .i_row  (r_cur_row),
    .i_col  (r_cur_col),
    .i_dir  (w_nb_dir),
    .i_side (w_nb_side),
    .o_row  (w_nb_row),
    .o_col  (w_nb_col),
    .o_oob  (w_nb_oob)
  );

  assign w_is_exit = (r_cur_row == '0 || r_cur_row == LAST_ROW ||
                      r_cur_col == '0 || r_cur_col == LAST_COL) &&
                     !(r_cur_row == r_st_row && r_cur_col == r_st_col);

  always_comb begin
    w_state_nxt   = r_state;
    w_cur_row_nxt = r_cur_row;
    w_cur_col_nxt = r_cur_col;
    w_st_row_nxt  = r_st_row;
    w_st_col_nxt  = r_st_col;
    w_dir_nxt     = r_dir;
    w_rot_nxt     = r_rot;
    w_steps_nxt   = r_steps;
    w_row_nxt     = r_row;
    w_col_nxt     = r_col;
    w_oe_nxt      = 1'b0;
    w_we_nxt      = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = r_done;
    w_fail_nxt    = r_fail;
    w_code_nxt    = r_code;
    w_go_mark     = 1'b0;
    w_go_probe    = 1'b0;
    w_probe_st    = ST_PROBE_FWD;
    w_go_fail     = 1'b0;
    w_fail_code   = FAIL_NONE;

    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.start) begin
          w_state_nxt   = ST_RD_START;
          w_cur_row_nxt = bus.starting_row;
          w_cur_col_nxt = bus.starting_col;
          w_st_row_nxt  = bus.starting_row;
          w_st_col_nxt  = bus.starting_col;
          w_dir_nxt     = bus.start_dir;
          w_rot_nxt     = 2'd0;
          w_steps_nxt   = '0;
          w_done_nxt    = 1'b0;
          w_fail_nxt    = 1'b0;
          w_code_nxt    = FAIL_NONE;
          w_busy_nxt    = 1'b1;
          w_row_nxt     = bus.starting_row;
          w_col_nxt     = bus.starting_col;
          w_oe_nxt      = 1'b1;
        end
      end
      ST_RD_START:  w_state_nxt = ST_CHK_START;
      ST_CHK_START: begin
        if (bus.maze_in) begin
          w_go_fail   = 1'b1;
          w_fail_code = FAIL_START_WALL;
        end else begin
          w_go_mark = 1'b1;
        end
      end
      ST_MARK: begin
        if (w_is_exit) begin
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_go_probe = 1'b1;
          w_probe_st = ST_PROBE_SIDE;
        end
      end
      // A probe state without maze_oe means its neighbour was off the grid.
      ST_PROBE_SIDE: begin
        if (r_oe) w_state_nxt = ST_CHK_SIDE;
        else      w_go_probe  = 1'b1;
      end
      ST_PROBE_FWD: w_state_nxt = r_oe ? ST_CHK_FWD : ST_ROTATE;
      ST_CHK_SIDE, ST_CHK_FWD: begin
        if (!bus.maze_in) begin
          if (r_steps >= MAX_STEPS) begin
            w_go_fail   = 1'b1;
            w_fail_code = FAIL_TIMEOUT;
          end else begin
            w_go_mark   = 1'b1;
            w_steps_nxt = r_steps + STEP_ONE;
            w_rot_nxt   = 2'd0;
            if (r_state == ST_CHK_SIDE) w_dir_nxt = hand_turn(r_dir, LEFT);
          end
        end else if (r_state == ST_CHK_SIDE) begin
          w_go_probe = 1'b1;
        end else begin
          w_state_nxt = ST_ROTATE;
        end
      end
      ST_ROTATE: begin
        w_dir_nxt = away_turn(r_dir, LEFT);
        w_rot_nxt = r_rot + 2'd1;
        // Third rotation without a move: side, forward and both away turns were blocked.
        if (r_rot == 2'd2) begin
          w_go_fail   = 1'b1;
          w_fail_code = FAIL_ENCLOSED;
        end else begin
          w_go_probe = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // The cell just read (still on row/col) becomes the current cell.
    if (w_go_mark) begin
      w_state_nxt   = ST_MARK;
      w_cur_row_nxt = r_row;
      w_cur_col_nxt = r_col;
      w_we_nxt      = 1'b1;
    end
    if (w_go_probe) begin
      w_state_nxt = w_probe_st;
      w_oe_nxt    = !w_nb_oob;
      w_row_nxt   = w_nb_oob ? r_cur_row : w_nb_row;
      w_col_nxt   = w_nb_oob ? r_cur_col : w_nb_col;
    end
    if (w_go_fail) begin
      w_state_nxt = ST_FAIL;
      w_busy_nxt  = 1'b0;
      w_fail_nxt  = 1'b1;
      w_code_nxt  = w_fail_code;
      w_row_nxt   = r_cur_row;
      w_col_nxt   = r_cur_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_st_row  <= '0;
      r_st_col  <= '0;
      r_dir     <= DIR_E;
      r_rot     <= 2'd0;
      r_steps   <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_oe      <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_code    <= FAIL_NONE;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_row <= w_cur_row_nxt;
      r_cur_col <= w_cur_col_nxt;
      r_st_row  <= w_st_row_nxt;
      r_st_col  <= w_st_col_nxt;
      r_dir     <= w_dir_nxt;
      r_rot     <= w_rot_nxt;
      r_steps   <= w_steps_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_oe      <= w_oe_nxt;
      r_we      <= w_we_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_fail    <= w_fail_nxt;
      r_code    <= w_code_nxt;
    end
  end

  assign bus.row        = r_row;
  assign bus.col        = r_col;
  assign bus.maze_oe    = r_oe;
  assign bus.maze_we    = r_we;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.fail       = r_fail;
  assign bus.fail_code  = r_code;
  assign bus.step_count = r_steps;

endmodule
